// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs req/ack fetches and fills the IF/ID register.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  input  logic             id_stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             fetch_fault_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic             valid_q, valid_d;
  logic             started_q;
  logic             fault_q;
  logic [WIDTH-1:0] redir_target;
  logic             ifid_stalled;
  logic             fetch_done;

`ifdef FETCH_ALIGN_CHK_EN
  logic fault_d;

  // Sticky until reset: a misaligned target kills all further fetching.
  assign fault_d = fault_q | (redirect_i & (redirect_pc_i[1:0] != 2'b00));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign fault_q = 1'b0;
`endif

  assign redir_target  = redirect_pc_i & ALIGN_MASK;
  assign ifid_stalled  = valid_q & id_stall_i;
  assign imem_req_o    = started_q & (((state_q == FETCH) & ~fault_q) | (state_q == DRAIN));
  assign imem_addr_o   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign fetch_done    = imem_req_o & imem_ack_i;

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign pc_plus4_o    = instr_pc_q + FOUR;
  assign fetch_fault_o = fault_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    valid_d      = valid_q;

    if (redirect_i) begin
      valid_d = 1'b0;
      pc_d    = redir_target;
      case (state_q)
        FETCH: begin
          // An unacknowledged request must finish at its old address before the new target is fetched.
          if (imem_req_o && !imem_ack_i) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end
        HOLD:    state_d = FETCH;
        DRAIN:   if (fetch_done) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch_done) begin
            pc_d = pc_q + FOUR;
            if (ifid_stalled) begin
              skid_instr_d = imem_rdata_i;
              skid_pc_d    = pc_q;
              state_d      = HOLD;
            end else begin
              instr_d    = imem_rdata_i;
              instr_pc_d = pc_q;
              valid_d    = 1'b1;
            end
          end else if (!id_stall_i) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!id_stall_i) begin
            instr_d    = skid_instr_q;
            instr_pc_d = skid_pc_q;
            valid_d    = 1'b1;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (fetch_done) begin
            state_d = FETCH;
          end
          if (!id_stall_i) begin
            valid_d = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // started_q delays the very first request by one cycle after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      valid_q      <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      valid_q      <= valid_d;
      started_q    <= 1'b1;
    end
  end

endmodule
